// File: rtl/valu_ctrl_seq.sv
// valu_ctrl_seq: sequenced ALU control unit issuing one registered control word per datapath beat
module valu_ctrl_seq #(
  parameter int VLEN = 128,
  parameter int DP_W = 32,
  localparam int NBEATS = VLEN / DP_W,
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int CW = DP_W / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic [1:0]    df,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_ctrl,
  output logic [BW-1:0] beat_idx,
  output logic          out_last,
  output logic          vec_mode,
  output logic [CW-1:0] carry_cut,
  output logic          illegal
);
  typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;
  state_t state, state_n;
  logic dec_ok, dec_vec, valid_n, last_n, ill_n, vec_n;
  logic [2:0] dec_ctrl, ctrl_n;
  logic [CW-1:0] dec_cut, cut_n;
  logic [BW-1:0] idx_n, idx_inc;
  assign in_ready = state == IDLE;
  assign idx_inc = beat_idx + BW'(1);
  always_comb begin
    dec_ok = 1'b1;
    dec_vec = 1'b0;
    dec_ctrl = 3'b000;
    if (alu_op == 3'b000) begin
      case (funct)
        6'b100000: dec_ctrl = 3'b000;
        6'b100010: dec_ctrl = 3'b001;
        6'b100100: dec_ctrl = 3'b010;
        6'b100101: dec_ctrl = 3'b011;
        6'b101010: dec_ctrl = 3'b100;
        6'b011110: dec_vec = 1'b1;
        default:   dec_ok = 1'b0;
      endcase
    end else if (alu_op[2]) dec_ok = 1'b0;
    else dec_ctrl = (alu_op == 3'b001) ? 3'b001 : (alu_op == 3'b010) ? 3'b000 : 3'b011;
    if (dec_vec && df == 2'b11 && DP_W < 64) dec_ok = 1'b0;
    // a cut after every element-sized group of bytes splits the adder into lanes
    for (int i = 0; i < CW; i++) dec_cut[i] = dec_vec && (((i + 1) % (1 << df)) == 0);
    dec_cut[CW-1] = 1'b1;
  end
  always_comb begin
    state_n = state;
    valid_n = out_valid;
    last_n = out_last;
    ill_n = 1'b0;
    ctrl_n = alu_ctrl;
    idx_n = beat_idx;
    vec_n = vec_mode;
    cut_n = carry_cut;
    if (flush) begin
      state_n = IDLE;
      valid_n = 1'b0;
      last_n = 1'b0;
      idx_n = '0;
    end else if (state == IDLE && in_valid) begin
      state_n = dec_ok ? ISSUE : ERR;
      ill_n = !dec_ok;
      valid_n = dec_ok;
      last_n = dec_ok && (!dec_vec || NBEATS == 1);
      idx_n = '0;
      ctrl_n = dec_ok ? dec_ctrl : alu_ctrl;
      vec_n = dec_ok ? dec_vec : vec_mode;
      cut_n = dec_ok ? dec_cut : carry_cut;
    end else if (state == ISSUE && out_ready) begin
      state_n = out_last ? IDLE : ISSUE;
      valid_n = !out_last;
      last_n = !out_last && idx_inc == BW'(NBEATS - 1);
      idx_n = out_last ? '0 : idx_inc;
    end else if (state == ERR) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      illegal <= 1'b0;
      alu_ctrl <= 3'b000;
      beat_idx <= '0;
      vec_mode <= 1'b0;
      carry_cut <= '0;
    end else begin
      state <= state_n;
      out_valid <= valid_n;
      out_last <= last_n;
      illegal <= ill_n;
      alu_ctrl <= ctrl_n;
      beat_idx <= idx_n;
      vec_mode <= vec_n;
      carry_cut <= cut_n;
    end
  end
endmodule

// File: tb/tb_valu_ctrl_seq.sv
// tb_valu_ctrl_seq: table-driven decode vectors plus stall, flush and async-reset sequences
module tb_valu_ctrl_seq;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [2:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [1:0] df = 0;
  logic in_ready, out_valid, out_last, vec_mode, illegal;
  logic [2:0] alu_ctrl;
  logic [1:0] beat_idx;
  logic [3:0] carry_cut;
  int passed = 0, total = 0;

  valu_ctrl_seq #(.VLEN(128), .DP_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .df(df), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .beat_idx(beat_idx), .out_last(out_last), .vec_mode(vec_mode),
    .carry_cut(carry_cut), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [1:0] df;
    logic       ill;
    logic [2:0] ctrl;
    logic       vec;
    logic [3:0] cut;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " illegal"}, 32'(illegal), 0);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    chk({tag, " beat_idx"}, 32'(beat_idx), 0);
  endtask

  task automatic accept(input logic [2:0] op, input logic [5:0] fn, input logic [1:0] d);
    @(negedge clk);
    chk("idle before accept", 32'(in_ready), 1);
    in_valid = 1; alu_op = op; funct = fn; df = d;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
  endtask

  task automatic run_entry(input vec_t e, input int n);
    int nb, c;
    string tag;
    tag = $sformatf("vec%0d", n);
    nb = e.ill ? 0 : (e.vec ? 4 : 1);
    out_ready = 1;
    accept(e.op, e.fn, e.df);
    c = 0;
    while (!in_ready && c < 10) begin
      chk({tag, " illegal"}, 32'(illegal), 32'(e.ill && c == 0));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(c < nb));
      if (out_valid) begin
        chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
        chk({tag, " vec_mode"}, 32'(vec_mode), 32'(e.vec));
        chk({tag, " carry_cut"}, 32'(carry_cut), 32'(e.cut));
        chk({tag, " beat_idx"}, 32'(beat_idx), 32'(c));
        chk({tag, " out_last"}, 32'(out_last), 32'(c == nb - 1));
      end
      c++;
      @(negedge clk);
    end
    chk({tag, " cycles to idle"}, 32'(c), 32'(e.ill ? 1 : nb));
  endtask

  initial begin
    int k;
    tbl[0]  = '{3'b000, 6'b100000, 2'b00, 0, 3'b000, 0, 4'b1000};
    tbl[1]  = '{3'b000, 6'b100010, 2'b00, 0, 3'b001, 0, 4'b1000};
    tbl[2]  = '{3'b000, 6'b100100, 2'b01, 0, 3'b010, 0, 4'b1000};
    tbl[3]  = '{3'b000, 6'b100101, 2'b00, 0, 3'b011, 0, 4'b1000};
    tbl[4]  = '{3'b000, 6'b101010, 2'b00, 0, 3'b100, 0, 4'b1000};
    tbl[5]  = '{3'b000, 6'b011110, 2'b00, 0, 3'b000, 1, 4'b1111};
    tbl[6]  = '{3'b000, 6'b011110, 2'b01, 0, 3'b000, 1, 4'b1010};
    tbl[7]  = '{3'b000, 6'b011110, 2'b10, 0, 3'b000, 1, 4'b1000};
    tbl[8]  = '{3'b000, 6'b011110, 2'b11, 1, 3'b000, 0, 4'b0000};
    tbl[9]  = '{3'b000, 6'b000111, 2'b00, 1, 3'b000, 0, 4'b0000};
    tbl[10] = '{3'b001, 6'b000000, 2'b00, 0, 3'b001, 0, 4'b1000};
    tbl[11] = '{3'b010, 6'b101010, 2'b00, 0, 3'b000, 0, 4'b1000};
    tbl[12] = '{3'b011, 6'b100000, 2'b10, 0, 3'b011, 0, 4'b1000};
    tbl[13] = '{3'b100, 6'b100000, 2'b00, 1, 3'b000, 0, 4'b0000};
    tbl[14] = '{3'b111, 6'b011110, 2'b00, 1, 3'b000, 0, 4'b0000};
    #2;
    reset_checks("reset");
    chk("reset alu_ctrl", 32'(alu_ctrl), 0);
    chk("reset carry_cut", 32'(carry_cut), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset vec_mode", 32'(vec_mode), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    foreach (tbl[i]) run_entry(tbl[i], i);
    // vector half-word with three stalled cycles on beat 1
    accept(3'b000, 6'b011110, 2'b01);
    k = 1;
    while (!in_ready && k < 20) begin
      if (k >= 2 && k <= 5) begin
        chk("stall beat_idx", 32'(beat_idx), 1);
        chk("stall carry_cut", 32'(carry_cut), 32'(4'b1010));
        chk("stall out_valid", 32'(out_valid), 1);
      end
      out_ready = !(k >= 2 && k <= 4);
      k++;
      @(negedge clk);
    end
    chk("stall cycles to idle", 32'(k), 8);
    out_ready = 1;
    // flush on beat 2
    accept(3'b000, 6'b011110, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("flush pre beat_idx", 32'(beat_idx), 2);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush in_ready", 32'(in_ready), 1);
    chk("flush illegal", 32'(illegal), 0);
    run_entry('{3'b011, 6'b000000, 2'b00, 0, 3'b011, 0, 4'b1000}, 100);
    // asynchronous reset between edges, during a beat and during an illegal pulse
    accept(3'b000, 6'b011110, 2'b00);
    @(negedge clk);
    chk("pre reset beat_idx", 32'(beat_idx), 1);
    #2 reset = 1;
    #1 reset_checks("async beat");
    @(negedge clk);
    reset = 0;
    accept(3'b000, 6'b111111, 2'b00);
    chk("pre reset illegal", 32'(illegal), 1);
    #2 reset = 1;
    #1 reset_checks("async illegal");
    @(negedge clk);
    reset = 0;
    run_entry(tbl[6], 200);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
